// File: rtl/matchstick_game_core.sv
// Shared-pile matchstick game controller for NUM_PLAYERS players: move validation,
// turn rotation, end-of-game detection (normal or misere) and optional turn timeout.
module matchstick_game_core #(
  parameter int NUM_PLAYERS = 2,
  parameter int PILE_W      = 8,
  parameter int INIT_PILE   = 100,
  parameter int MAX_TAKE    = 10,
  parameter int TAKE_W      = 4,
  parameter int MISERE      = 0,
  parameter int TIMEOUT_CYC = 0,
  parameter int PLR_W       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              new_game_i,
  input  logic              move_valid_i,
  input  logic [TAKE_W-1:0] take_i,
  output logic [PILE_W-1:0] pile_o,
  output logic [PLR_W-1:0]  turn_o,
  output logic              move_ok_o,
  output logic              move_err_o,
  output logic              timeout_o,
  output logic              game_over_o,
  output logic [PLR_W-1:0]  winner_o
);

  localparam bit PARAMS_OK =
    (NUM_PLAYERS >= 2) && (NUM_PLAYERS <= 8) &&
    (INIT_PILE >= 0) && (longint'(INIT_PILE) < (longint'(1) << PILE_W)) &&
    (MAX_TAKE >= 0) && (longint'(MAX_TAKE) < (longint'(1) << TAKE_W)) &&
    ((longint'(1) << PLR_W) >= longint'(NUM_PLAYERS)) &&
    (TIMEOUT_CYC >= 0);

  generate
    if (!PARAMS_OK) begin : g_param_check
      $error("matchstick_game_core: illegal parameter combination");
    end
  endgenerate

  // Compare width wide enough for both the pile and the raw take value.
  localparam int CMP_W    = (PILE_W > TAKE_W) ? PILE_W : TAKE_W;
  localparam int TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TMR_LAST = (TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0;

  localparam logic [PILE_W-1:0] INIT_VAL  = PILE_W'(INIT_PILE);
  localparam logic [CMP_W-1:0]  MAX_VAL   = CMP_W'(MAX_TAKE);
  localparam logic [PLR_W-1:0]  LAST_PLR  = PLR_W'(NUM_PLAYERS - 1);
  localparam logic [TMR_W-1:0]  TMR_END   = TMR_W'(TMR_LAST);

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PILE_W-1:0]  pile_q, pile_d;
  logic [PLR_W-1:0]   turn_q, turn_d;
  logic [PLR_W-1:0]   winner_q, winner_d;
  logic               ok_q, ok_d;
  logic               err_q, err_d;
  logic               tout_q, tout_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic               take_nz;
  logic               take_legal;
  logic [CMP_W-1:0]   take_ext;
  logic [CMP_W-1:0]   pile_ext;
  logic [PILE_W-1:0]  pile_after;

  function automatic logic [PLR_W-1:0] next_player(input logic [PLR_W-1:0] p);
    if (p == LAST_PLR) begin
      return '0;
    end
    return p + PLR_W'(1);
  endfunction

  assign take_ext   = CMP_W'(take_i);
  assign pile_ext   = CMP_W'(pile_q);
  assign take_nz    = (take_i != '0);
  // Legal take: non-zero and within min(MAX_TAKE, pile).
  assign take_legal = take_nz && (take_ext <= MAX_VAL) && (take_ext <= pile_ext);
  assign pile_after = pile_q - PILE_W'(take_i);

  always_comb begin
    state_d  = state_q;
    pile_d   = pile_q;
    turn_d   = turn_q;
    winner_d = winner_q;
    ok_d     = ok_q;
    err_d    = err_q;
    tout_d   = 1'b0;
    timer_d  = timer_q;

    if (new_game_i) begin
      state_d  = PLAY;
      pile_d   = INIT_VAL;
      turn_d   = '0;
      winner_d = '0;
      ok_d     = 1'b1;
      err_d    = 1'b0;
      timer_d  = '0;
    end else begin
      case (state_q)
        PLAY: begin
          if (move_valid_i && take_legal) begin
            pile_d  = pile_after;
            ok_d    = 1'b1;
            err_d   = 1'b0;
            timer_d = '0;
            if (pile_after == '0) begin
              state_d  = OVER;
              winner_d = (MISERE != 0) ? next_player(turn_q) : turn_q;
            end else begin
              turn_d = next_player(turn_q);
            end
          end else begin
            if (move_valid_i && take_nz) begin
              ok_d  = 1'b0;
              err_d = 1'b1;
            end
            if (TIMEOUT_CYC > 0) begin
              if (timer_q == TMR_END) begin
                turn_d  = next_player(turn_q);
                tout_d  = 1'b1;
                timer_d = '0;
              end else begin
                timer_d = timer_q + TMR_W'(1);
              end
            end
          end
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d = PLAY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PLAY;
      pile_q   <= INIT_VAL;
      turn_q   <= '0;
      winner_q <= '0;
      ok_q     <= 1'b1;
      err_q    <= 1'b0;
      tout_q   <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      pile_q   <= pile_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      tout_q   <= tout_d;
      timer_q  <= timer_d;
    end
  end

  assign pile_o      = pile_q;
  assign turn_o      = turn_q;
  assign winner_o    = winner_q;
  assign move_ok_o   = ok_q;
  assign move_err_o  = err_q;
  assign timeout_o   = tout_q;
  assign game_over_o = (state_q == OVER);

endmodule
